// File: rtl/mem_copy_dma_if.sv
// Control and memory-bus signals of the byte-copy DMA.
// master is the DMA side; slave is the controller/memory side.
interface mem_copy_dma_if #(
    parameter int unsigned AW = 7,
    parameter int unsigned DW = 8,
    parameter int unsigned LW = 4
);
    logic          start;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] checksum;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    modport master (
        input  start, src, dst, len, mem_dout,
        output busy, done, err, checksum, mem_we, mem_addr, mem_din
    );

    modport slave (
        output start, src, dst, len, mem_dout,
        input  busy, done, err, checksum, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_copy_dma.sv
// Byte-wise memory copy engine: one read and one write per byte, ascending order,
// with an additive 8-bit checksum of the moved data.
module mem_copy_dma #(
    parameter int unsigned AW = 7,
    parameter int unsigned DW = 8,
    parameter int unsigned LW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_copy_dma_if.master    bus
);
    localparam logic [LW-1:0] MaxLen = LW'(8);
    localparam logic [AW:0]   MemTop = (AW+1)'(1) << AW;

    typedef enum logic [1:0] {StIdle, StRd, StWr, StFin} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] sum_q, sum_d;
    logic          err_q, err_d;

    logic [AW:0]   dst_end;
    logic          illegal;

    // Destination must lie wholly in the upper (SRAM) half without wrapping.
    assign dst_end = {1'b0, bus.dst} + (AW+1)'(bus.len);
    assign illegal = (bus.len > MaxLen) || !bus.dst[AW-1] || (dst_end > MemTop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        data_d  = data_q;
        sum_d   = sum_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    src_d = bus.src;
                    dst_d = bus.dst;
                    rem_d = bus.len;
                    sum_d = '0;
                    err_d = 1'b0;
                    if (illegal) begin
                        err_d   = 1'b1;
                        state_d = StFin;
                    end else if (bus.len == '0) begin
                        state_d = StFin;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                data_d  = bus.mem_dout;
                sum_d   = sum_q + bus.mem_dout;
                state_d = StWr;
            end
            StWr: begin
                src_d   = src_q + AW'(1);
                dst_d   = dst_q + AW'(1);
                rem_d   = rem_q - LW'(1);
                state_d = (rem_q == LW'(1)) ? StFin : StRd;
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_din  = '0;
        bus.err      = err_q;
        bus.checksum = sum_q;
        case (state_q)
            StRd: begin
                bus.busy     = 1'b1;
                bus.mem_addr = src_q;
            end
            StWr: begin
                bus.busy     = 1'b1;
                bus.mem_we   = 1'b1;
                bus.mem_addr = dst_q;
                bus.mem_din  = data_q;
            end
            StFin:   bus.done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed and randomized copies against a ROM/SRAM model, with an array-level
// reference of the expected memory image, checksum, error and timing.
module tb_mem_copy_dma;
    logic clk;
    logic rst_n;
    logic preset;
    int   vectors;
    int   miscompares;

    logic [7:0] sram     [64];
    logic [7:0] ref_sram [64];

    mem_copy_dma_if dif ();

    mem_copy_dma dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [6:0] a);
        logic [7:0] f;
        case (a[2:0])
            3'd0: f = 8'd1;
            3'd1: f = 8'd1;
            3'd2: f = 8'd2;
            3'd3: f = 8'd3;
            3'd4: f = 8'd5;
            3'd5: f = 8'd8;
            3'd6: f = 8'd13;
            default: f = 8'd21;
        endcase
        return f + {6'b0, a[4:3]};
    endfunction

    assign dif.mem_dout = (dif.mem_addr < 7'd64) ? rom(dif.mem_addr) : sram[dif.mem_addr[5:0]];

    always @(posedge clk) begin
        if (preset) begin
            for (int i = 0; i < 64; i++) sram[i] <= 8'hAA;
        end else if (dif.mem_we && dif.mem_addr >= 7'd64) begin
            sram[dif.mem_addr[5:0]] <= dif.mem_din;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_rd(input int a);
        logic [6:0] a7;
        a7 = 7'(a % 128);
        return (a7 < 7'd64) ? rom(a7) : ref_sram[a7[5:0]];
    endfunction

    task automatic check_sram(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 64; i++) if (sram[i] !== ref_sram[i]) bad++;
        check(tag, bad, 0);
    endtask

    // Runs one request; if poke, start is also pulsed mid-transfer and during done.
    task automatic xfer(input logic [6:0] s, input logic [6:0] d, input logic [3:0] l,
                        input bit poke);
        bit         exp_err;
        logic [7:0] exp_sum;
        logic [7:0] b;
        int         exp_lat, n, nbusy, nwe, badwe;
        bit         seen;

        exp_err = (l > 4'd8) || (d < 7'd64) || (int'(d) + int'(l) > 128);
        exp_sum = 8'd0;
        if (!exp_err) begin
            for (int i = 0; i < int'(l); i++) begin
                b = model_rd(int'(s) + i);
                exp_sum += b;
                ref_sram[(int'(d) + i) - 64] = b;
            end
        end
        exp_lat = exp_err ? 0 : 2 * int'(l);

        dif.src = s; dif.dst = d; dif.len = l; dif.start = 1'b1;
        @(posedge clk); #1;
        dif.start = 1'b0;
        n = 0; nbusy = 0; nwe = 0; badwe = 0; seen = 1'b0;
        while (n < 40) begin
            if (dif.done) begin
                seen = 1'b1;
                break;
            end
            if (dif.busy) nbusy++;
            if (dif.mem_we) nwe++;
            if (dif.mem_we && dif.mem_addr < 7'd64) badwe++;
            dif.start = poke && (n == 2);
            if (poke && n == 2) begin
                dif.src = 7'd5; dif.dst = 7'd120; dif.len = 4'd3;
            end
            @(posedge clk); #1;
            dif.start = 1'b0;
            n++;
        end
        check("done_seen", seen, 1);
        check("latency", n, exp_lat);
        check("busy_cycles", nbusy, exp_lat);
        check("write_cycles", nwe, exp_err ? 0 : int'(l));
        check("write_addr_low", badwe, 0);
        check("err_at_done", dif.err, exp_err);
        check("sum_at_done", dif.checksum, exp_sum);
        check("busy_at_done", dif.busy, 0);
        if (poke) begin
            dif.src = 7'd0; dif.dst = 7'd64; dif.len = 4'd2; dif.start = 1'b1;
        end
        @(posedge clk); #1;
        dif.start = 1'b0;
        check("done_pulse_1cyc", dif.done, 0);
        check("idle_busy", dif.busy, 0);
        check("err_held", dif.err, exp_err);
        check("sum_held", dif.checksum, exp_sum);
        check_sram("sram_image");
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; preset = 1'b1;
        dif.start = 1'b0; dif.src = '0; dif.dst = '0; dif.len = '0;
        for (int i = 0; i < 64; i++) ref_sram[i] = 8'hAA;
        #1;
        check("rst_busy", dif.busy, 0);
        check("rst_done", dif.done, 0);
        check("rst_err", dif.err, 0);
        check("rst_sum", dif.checksum, 0);
        check("rst_we", dif.mem_we, 0);
        check("rst_addr", dif.mem_addr, 0);
        check("rst_din", dif.mem_din, 0);
        @(posedge clk); #1;
        preset = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;

        // Fibonacci ROM bank 0 into SRAM base.
        xfer(7'd0, 7'd64, 4'd8, 1'b0);
        check("c1_sum_const", dif.checksum, 54);
        check("c1_last_byte", sram[7], 21);
        xfer(7'd24, 7'd100, 4'd4, 1'b1);
        check("c2_sum_const", dif.checksum, 19);
        xfer(7'd0, 7'd8, 4'd2, 1'b0);
        xfer(7'd0, 7'd125, 4'd4, 1'b0);
        xfer(7'd3, 7'd64, 4'd0, 1'b0);
        xfer(7'd3, 7'd64, 4'd9, 1'b0);
        check("c4_len9_err", dif.err, 1);
        xfer(7'd0, 7'd124, 4'd4, 1'b0);  // last legal byte at 127

        // Reset asserted during the third write of an 8-byte copy.
        preset = 1'b1;
        @(posedge clk); #1;
        preset = 1'b0;
        for (int i = 0; i < 64; i++) ref_sram[i] = 8'hAA;
        dif.src = 7'd0; dif.dst = 7'd64; dif.len = 4'd8; dif.start = 1'b1;
        @(posedge clk); #1;
        dif.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("c5_in_wr3", dif.mem_we, 1);
        check("c5_wr3_addr", dif.mem_addr, 66);
        rst_n = 1'b0;
        #1;
        check("c5_busy", dif.busy, 0);
        check("c5_done", dif.done, 0);
        check("c5_we", dif.mem_we, 0);
        check("c5_addr", dif.mem_addr, 0);
        check("c5_din", dif.mem_din, 0);
        check("c5_sum", dif.checksum, 0);
        ref_sram[0] = 8'd1;
        ref_sram[1] = 8'd1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("c5_idle_done", dif.done, 0);
        check_sram("c5_sram");

        // Busy-time start ignored, then a normal run resets the checksum.
        xfer(7'd10, 7'd80, 4'd6, 1'b1);
        xfer(7'd70, 7'd72, 4'd5, 1'b0);  // overlapping SRAM ranges

        for (int t = 0; t < 24; t++) begin
            logic [6:0] s, d;
            logic [3:0] l;
            s = 7'($urandom_range(0, 127));
            d = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                            : 7'($urandom_range(64, 127));
            l = 4'($urandom_range(0, 10));
            xfer(s, d, l, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
